// File: rtl/alu_exec_if.sv
// Handshake bundle for the execute unit.
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. Ready may depend on state only, never on valid.
//
//   upstream side  : in_valid, in_ready, alu_inst, op_a, op_b
//   downstream side: out_valid, out_ready, result, carry, branch_taken, illegal
//
// The master modport is the side that issues operations and consumes results.
// The slave modport is the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_inst;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             branch_taken;
  logic             illegal;

  modport master (
    output in_valid, alu_inst, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry, branch_taken, illegal
  );

  modport slave (
    input  in_valid, alu_inst, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry, branch_taken, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute unit: takes a decoded 4-bit ALU op and two operands, and returns a
// registered result with carry/borrow, a branch-compare outcome and an
// illegal-opcode flag.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       alu_exec_if.slave (in/out valid-ready handshake plus payloads)
//   dbg_state current FSM state (0 IDLE, 1 SHIFT, 2 DONE), used for observation only
//
// Arithmetic, compare and illegal ops complete in one cycle. Shifts move one
// bit position per cycle, so a shift by k takes k+1 cycles from accept to
// out_valid. A result stays in DONE until the consumer takes it. The handoff
// cycle never accepts a new op, so throughput is at most one op per 2 cycles.
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_if.slave     bus,
  output logic [1:0]    dbg_state
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SFL = 4'b0010;
  localparam logic [3:0] OP_SFR = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_DEC = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] OP_BLT = 4'b1000;

  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [SHW-1:0]   ONE_SH = SHW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 1 = logical right shift
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             taken_q, taken_d;
  logic             ill_q, ill_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] acc_sh;
  logic [SHW-1:0]   shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    res_d   = res_q;
    carry_d = carry_q;
    taken_d = taken_q;
    ill_d   = ill_q;
    sum_ext = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    shamt   = bus.op_b[SHW-1:0];
    acc_sh  = dir_q ? (acc_q >> 1) : (acc_q << 1);

    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone means accept.
        if (bus.in_valid) begin
          state_d = DONE;
          res_d   = '0;
          carry_d = 1'b0;
          taken_d = 1'b0;
          ill_d   = 1'b0;
          case (bus.alu_inst)
            OP_ADD: begin
              res_d   = sum_ext[WIDTH-1:0];
              carry_d = sum_ext[WIDTH];
            end
            OP_SUB: begin
              res_d   = bus.op_a - bus.op_b;
              carry_d = (bus.op_a < bus.op_b);
            end
            OP_INC: begin
              res_d   = bus.op_a + ONE_W;
              carry_d = &bus.op_a;
            end
            OP_DEC: begin
              res_d   = bus.op_a - ONE_W;
              carry_d = (bus.op_a == '0);
            end
            OP_BNE: taken_d = (bus.op_a != bus.op_b);
            OP_BEQ: taken_d = (bus.op_a == bus.op_b);
            OP_BLT: taken_d = (bus.op_a < bus.op_b);
            OP_SFL, OP_SFR: begin
              if (shamt == '0) begin
                res_d = bus.op_a;
              end else begin
                // Outputs keep their old values until the DONE entry edge.
                state_d = SHIFT;
                acc_d   = bus.op_a;
                cnt_d   = shamt;
                dir_d   = (bus.alu_inst == OP_SFR);
                res_d   = res_q;
                carry_d = carry_q;
                taken_d = taken_q;
                ill_d   = ill_q;
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end

      SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - ONE_SH;
        // cnt_q == 1 means this edge applies the last shift.
        if (cnt_q == ONE_SH) begin
          state_d = DONE;
          res_d   = acc_sh;
          carry_d = 1'b0;
          taken_d = 1'b0;
          ill_d   = 1'b0;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.result       = res_q;
  assign bus.carry        = carry_q;
  assign bus.branch_taken = taken_q;
  assign bus.illegal      = ill_q;
  assign dbg_state        = state_q;

endmodule
